// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target slice.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins and register-port signals of the I2C target.
interface i2c_target_if #(
    parameter int unsigned REG_AW = 8
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_drive_low_o;
    logic              wr_en_o;
    logic [REG_AW-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic [7:0]        rd_data_i;
    logic              busy_o;

    modport slave (
        input  scl_i, sda_i, rd_data_i,
        output sda_drive_low_o, wr_en_o, wr_addr_o, wr_data_o, rd_addr_o, busy_o
    );

    modport master (
        output scl_i, sda_i, rd_data_i,
        input  sda_drive_low_o, wr_en_o, wr_addr_o, wr_data_o, rd_addr_o, busy_o
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, optional stability filter (I2C_TARGET_GLITCH_FILTER_EN)
// and edge / START / STOP detection. Bit 0 carries SCL, bit 1 carries SDA.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] filt;
    logic [1:0] prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= '1;
            sync <= '1;
            prev <= '1;
        end else begin
            meta <= {sda_i, scl_i};
            sync <= meta;
            prev <= filt;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist1;
    logic [1:0] hist2;
    logic [1:0] held;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist1 <= '1;
            hist2 <= '1;
            held  <= '1;
        end else begin
            hist1 <= sync;
            hist2 <= hist1;
            held  <= filt;
        end
    end

    // New level passes only once three consecutive samples agree.
    always_comb begin
        filt = held;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync[i] == hist1[i] && hist1[i] == hist2[i])
                filt[i] = sync[i];
        end
    end
`else
    always_comb filt = sync;
`endif

    assign scl_rise  =  filt[0] & ~prev[0];
    assign scl_fall  = ~filt[0] &  prev[0];
    assign start_det =  filt[0] &  prev[0] &  prev[1] & ~filt[1];
    assign stop_det  =  filt[0] &  prev[0] & ~prev[1] &  filt[1];
    assign sda_s     =  filt[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address and a register-port to a local bank.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int unsigned           REG_AW      = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    i2c_target_if.slave  bus
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_bus_sync u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t    state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [REG_AW-1:0] ptr;
    logic              rw;
    logic              sda_low;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic [7:0]        rx_byte;

    assign rx_byte = {shreg[6:0], sda_s};

    // In the ACK states the first falling edge starts the drive and the
    // second one ends it, so sda_low doubles as the ACK phase marker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            sda_low <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, IGNORE: ;
                    ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            rw      <= rx_byte[0];
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                            end else begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else if (rw) begin
                            state   <= RDATA;
                            bit_cnt <= '0;
                            sda_low <= ~bus.rd_data_i[7];
                            shreg   <= {bus.rd_data_i[6:0], 1'b1};
                        end else begin
                            state   <= REG;
                            sda_low <= 1'b0;
                        end
                    end
                    REG: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ptr     <= rx_byte[REG_AW-1:0];
                            state   <= REG_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    REG_ACK: if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else begin
                            sda_low <= 1'b0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            wr_en   <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= rx_byte;
                            state   <= WDATA_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    WDATA_ACK: if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else begin
                            sda_low <= 1'b0;
                            ptr     <= ptr + REG_AW'(1);
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_low <= 1'b0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_low <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b1};
                            end
                        end
                    end
                    // bit_cnt==1 marks an ACK seen on the rise; reload on the fall.
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                ptr     <= ptr + REG_AW'(1);
                                bit_cnt <= 4'd1;
                            end else begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= RDATA;
                            bit_cnt <= '0;
                            sda_low <= ~bus.rd_data_i[7];
                            shreg   <= {bus.rd_data_i[6:0], 1'b1};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_drive_low_o = sda_low;
    assign bus.wr_en_o         = wr_en;
    assign bus.wr_addr_o       = wr_addr;
    assign bus.wr_data_o       = wr_data;
    assign bus.rd_addr_o       = ptr;
    assign bus.busy_o          = busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: open-drain bus master model plus register bank.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int unsigned Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] bank [256];

    int n_checks = 0;
    int n_fail   = 0;
    int wcnt     = 0;
    int drv_cnt  = 0;
    logic [7:0] wlog_addr [16];
    logic [7:0] wlog_data [16];

    always #5 clk = ~clk;

    i2c_target_if #(.REG_AW(8)) bus ();

    i2c_target #(.TARGET_ADDR(7'h50), .REG_AW(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.scl_i     = m_scl;
    assign bus.sda_i     = m_sda & ~bus.sda_drive_low_o;
    assign bus.rd_data_i = bank[bus.rd_addr_o];

    always @(negedge clk) begin
        if (bus.wr_en_o) begin
            wlog_addr[wcnt % 16] <= bus.wr_addr_o;
            wlog_data[wcnt % 16] <= bus.wr_data_o;
            wcnt <= wcnt + 1;
        end
        if (bus.sda_drive_low_o) drv_cnt <= drv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            m_sda = 1'b1; wait_clk(Q);
            m_scl = 1'b1; wait_clk(Q);
        end
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] value, input int unsigned n);
        logic [7:0] v;
        v = value;
        for (int unsigned i = 0; i < n; i++) begin
            m_sda = v[7];
            v = {v[6:0], 1'b0};
            wait_clk(Q);
            m_scl = 1'b1; wait_clk(2 * Q);
            m_scl = 1'b0; wait_clk(Q);
        end
    endtask

    task automatic get_ack(output logic ack);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        ack = bus.sda_i;
        wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] value, output logic ack);
        send_bits(value, 8);
        get_ack(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] data);
        data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m_sda = 1'b1; wait_clk(Q);
            m_scl = 1'b1; wait_clk(Q);
            data = {data[6:0], bus.sda_i};
            wait_clk(Q);
            m_scl = 1'b0; wait_clk(Q);
        end
        m_sda = nack; wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base;

        for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'h5A;
        bank[3] = 8'hC3;
        bank[4] = 8'h7E;

        wait_clk(4);
        check_eq("rst_drive",   32'(bus.sda_drive_low_o), 32'h0);
        check_eq("rst_wr_en",   32'(bus.wr_en_o),         32'h0);
        check_eq("rst_wr_addr", 32'(bus.wr_addr_o),       32'h0);
        check_eq("rst_wr_data", 32'(bus.wr_data_o),       32'h0);
        check_eq("rst_rd_addr", 32'(bus.rd_addr_o),       32'h0);
        check_eq("rst_busy",    32'(bus.busy_o),          32'h0);
        rst = 1'b0;
        wait_clk(Q);

        // Single write
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("w1_ack_addr", 32'(ack), 32'(I2C_ACK));
        check_eq("w1_busy", 32'(bus.busy_o), 32'h1);
        send_byte(8'h02, ack); check_eq("w1_ack_reg", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h5A, ack); check_eq("w1_ack_data", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        wait_clk(Q);
        check_eq("w1_busy_stop", 32'(bus.busy_o), 32'h0);
        check_eq("w1_count", 32'(wcnt - base), 32'd1);
        check_eq("w1_addr", 32'(wlog_addr[base % 16]), 32'h02);
        check_eq("w1_data", 32'(wlog_data[base % 16]), 32'h5A);

        // Burst write with pointer wrap
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("w2_ack_addr", 32'(ack), 32'(I2C_ACK));
        send_byte(8'hFF, ack); check_eq("w2_ack_reg", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h11, ack); check_eq("w2_ack_d0", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h22, ack); check_eq("w2_ack_d1", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        wait_clk(Q);
        check_eq("w2_count", 32'(wcnt - base), 32'd2);
        check_eq("w2_addr0", 32'(wlog_addr[base % 16]), 32'hFF);
        check_eq("w2_data0", 32'(wlog_data[base % 16]), 32'h11);
        check_eq("w2_addr1", 32'(wlog_addr[(base + 1) % 16]), 32'h00);
        check_eq("w2_data1", 32'(wlog_data[(base + 1) % 16]), 32'h22);

        // Combined read
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("r_ack_addr", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h03, ack); check_eq("r_ack_reg", 32'(ack), 32'(I2C_ACK));
        i2c_start();
        send_byte(8'hA1, ack); check_eq("r_ack_addr_rd", 32'(ack), 32'(I2C_ACK));
        read_byte(I2C_ACK, d);  check_eq("r_data0", 32'(d), 32'hC3);
        read_byte(I2C_NACK, d); check_eq("r_data1", 32'(d), 32'h7E);
        check_eq("r_busy_nack", 32'(bus.busy_o), 32'h0);
        i2c_stop();
        wait_clk(Q);
        check_eq("r_no_write", 32'(wcnt - base), 32'd0);

        // Address mismatch, then a valid write
        base = drv_cnt;
        i2c_start();
        send_byte(8'h62, ack); check_eq("mm_nack_addr", 32'(ack), 32'(I2C_NACK));
        send_byte(8'h01, ack); check_eq("mm_nack_reg", 32'(ack), 32'(I2C_NACK));
        check_eq("mm_busy", 32'(bus.busy_o), 32'h0);
        i2c_stop();
        wait_clk(Q);
        check_eq("mm_no_drive", 32'(drv_cnt - base), 32'd0);
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("mm_w_ack", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h05, ack);
        send_byte(8'h99, ack);
        i2c_stop();
        wait_clk(Q);
        check_eq("mm_w_count", 32'(wcnt - base), 32'd1);
        check_eq("mm_w_addr", 32'(wlog_addr[base % 16]), 32'h05);
        check_eq("mm_w_data", 32'(wlog_data[base % 16]), 32'h99);

        // Reset while driving a read 0 bit (third bit of 0xC3)
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        for (int i = 0; i < 2; i++) begin
            m_sda = 1'b1; wait_clk(Q);
            m_scl = 1'b1; wait_clk(2 * Q);
            m_scl = 1'b0; wait_clk(Q);
        end
        check_eq("rs_drive_before", 32'(bus.sda_drive_low_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("rs_drive_async", 32'(bus.sda_drive_low_o), 32'h0);
        check_eq("rs_state", 32'(dut.state), 32'(IDLE));
        check_eq("rs_busy", 32'(bus.busy_o), 32'h0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(Q);
        check_eq("rs_no_false_start", 32'(dut.state), 32'(IDLE));

        // Partial byte cut by STOP
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h07, ack);
        send_bits(8'hF0, 4);
        i2c_stop();
        wait_clk(Q);
        check_eq("pb_no_write", 32'(wcnt - base), 32'd0);
        check_eq("pb_busy", 32'(bus.busy_o), 32'h0);

        // 2-clk SCL low glitch in the high phase of the first data bit
        base = wcnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h10, ack);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(4);
        m_scl = 1'b0; wait_clk(2);
        m_scl = 1'b1; wait_clk(2 * Q - 6);
        m_scl = 1'b0; wait_clk(Q);
        send_bits(8'hB4, 7);
        get_ack(ack);
        i2c_stop();
        wait_clk(Q);
        check_eq("gl_count", 32'(wcnt - base), 32'd1);
        check_eq("gl_addr", 32'(wlog_addr[base % 16]), 32'h10);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check_eq("gl_data", 32'(wlog_data[base % 16]), 32'h5A);
        check_eq("gl_ack", 32'(ack), 32'(I2C_ACK));
`else
        check_eq("gl_data", 32'(wlog_data[base % 16]), 32'h2D);
        check_eq("gl_ack", 32'(ack), 32'(I2C_NACK));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
